set_bit_iterator_32: RTL and testbench
======================================

Name: set_bit_iterator_32

Overview:
- Sequential counterpart to the bitwise-OR datapath. OR merges per-source bits into one 32-bit mask; this block takes such a merged mask apart again.
- Accepts a 32-bit mask, then emits the index of each set bit, one per handshake, lowest index first.
- Sits behind the ALU logic unit and interrupt/request-mask aggregation, where a consumer must service each flagged source individually.

Parameters:
- WIDTH, 32, mask width in bits.
- IDX_W, 5, index width; equals clog2(WIDTH).

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_mask is offered.
- in_ready  output  1  block can accept a mask.
- in_mask  input  WIDTH  mask to decompose.
- out_valid  output  1  out_index holds a valid set-bit index.
- out_ready  input  1  consumer accepts out_index.
- out_index  output  IDX_W  index of the lowest remaining set bit.
- out_last  output  1  current index is the final set bit of this mask.
- remaining  output  IDX_W+1  set bits not yet handed off, including the current one.
- empty  output  1  one-cycle pulse when an all-zero mask is accepted.

Behaviour:
- Reset (reset_n low, takes effect immediately):
  - State goes to IDLE; residual register and remaining are cleared.
  - out_valid=0, out_index=0, out_last=0, empty=0, in_ready=0.
  - in_ready goes to 1 on the first clock edge after reset_n deasserts.
  - Reset mid-scan discards the mask in progress; no further indices are emitted.
- States: IDLE, SCAN.
- IDLE:
  - in_ready=1, out_valid=0.
  - Accept happens on in_valid & in_ready at an edge.
  - Nonzero mask: residual <= in_mask; remaining <= popcount(in_mask); go to SCAN.
  - Zero mask: stay in IDLE; empty=1 for exactly the following cycle; no output beats.
- SCAN:
  - in_ready=0. in_valid is ignored; the mask is never replaced mid-scan.
  - out_valid=1.
  - out_index = position of the lowest set bit of residual (combinational from the register).
  - out_last = (remaining == 1).
  - Handshake (out_valid & out_ready) at an edge: residual <= residual & (residual - 1); remaining <= remaining - 1.
  - If out_last at that handshake, go to IDLE. in_ready=1 on the next cycle.
- Latency and throughput:
  - Mask accepted at edge N gives first out_valid in cycle N+1.
  - One index per cycle while out_ready stays high.
  - A mask with k set bits occupies the block for k cycles, followed by one IDLE cycle before the next accept.
- Stall: while out_ready=0, out_index, out_last and remaining hold stable.
- Outside SCAN: out_index=0 and out_last=0.
- Arithmetic:
  - remaining is IDX_W+1 bits so the value 32 is representable; it never underflows.
  - residual - 1 is a WIDTH-bit wrap, but it is only used when residual is nonzero.

Decomposition:
- Shared package holds: WIDTH, IDX_W, CNT_W (=IDX_W+1), and the state encoding constants (IDLE=0, SCAN=1).
- One sub-module: lsb_priority_enc_32. It is combinational: WIDTH-bit input → IDX_W lowest-set-bit index plus a nonzero flag. It is instantiated once on the residual register.
- popcount at load time stays inline.

Test Plan:
- Sparse mask: reset, in_mask=0x8000_0001, out_ready=1.
  - Indices 0 then 31 on consecutive cycles.
  - remaining shows 2 then 1; out_last only on the 31 beat.
  - in_ready=1 the cycle after.
- Zero mask: in_mask=0x0000_0000.
  - empty pulses high for one cycle.
  - out_valid never asserts; in_ready stays 1.
- Full mask with stalls: in_mask=0xFFFF_FFFF, out_ready toggled 1,0,1,0…
  - Indices 0..31 in order; remaining counts 32→1.
  - Values hold during the stall cycles; out_last only on index 31.
- Input ignored during scan: in_mask=0x0000_0300, then in_valid=1 with 0x0000_0001 during SCAN.
  - in_ready=0 throughout; only indices 8, 9 are emitted.
  - 0x1 is taken only once IDLE returns (index 0).
- Asynchronous reset mid-scan: in_mask=0x0000_00F0; after index 4 is handed off, pulse reset_n low between clock edges.
  - out_valid, out_index, remaining go to 0 immediately.
  - After release: IDLE, in_ready=1, no residual indices 5..7 emitted.
- Back-to-back masks: 0x0000_0001 then 0x4000_0000, in_valid held high.
  - Outputs are index 0 (last), one IDLE cycle, then index 30 (last).

Source files
------------

// File: rtl/set_bit_iterator_32_pkg.sv
// rtl/set_bit_iterator_32_pkg.sv - shared widths and state encoding for the set-bit iterator
package set_bit_iterator_32_pkg;

    localparam int WIDTH = 32;
    localparam int IDX_W = 5;
    localparam int CNT_W = IDX_W + 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

endpackage

// File: rtl/lsb_priority_enc_32.sv
// rtl/lsb_priority_enc_32.sv - combinational lowest-set-bit index encoder
module lsb_priority_enc_32
    import set_bit_iterator_32_pkg::*;
(
    input  logic [WIDTH-1:0] vec,
    output logic [IDX_W-1:0] index,
    output logic             nonzero
);

    // Walking from the top down lets the lowest set bit win the last assignment.
    always_comb begin
        index = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (vec[i]) begin
                index = IDX_W'(i);
            end
        end
    end

    assign nonzero = |vec;

endmodule

// File: rtl/set_bit_iterator_32.sv
// rtl/set_bit_iterator_32.sv - emits the index of each set bit of an accepted mask, lowest first
module set_bit_iterator_32
    import set_bit_iterator_32_pkg::*;
(
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_mask,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_index,
    output logic             out_last,
    output logic [CNT_W-1:0] remaining,
    output logic             empty
);

    state_t           state_q, state_nx;
    logic [WIDTH-1:0] residual_q, residual_nx;
    logic [CNT_W-1:0] cnt_q, cnt_nx;
    logic             armed_q;
    logic             empty_q, empty_nx;
    logic [CNT_W-1:0] load_count;
    logic [IDX_W-1:0] enc_index;
    logic             enc_nonzero;

    lsb_priority_enc_32 u_enc (
        .vec     (residual_q),
        .index   (enc_index),
        .nonzero (enc_nonzero)
    );

    always_comb begin
        load_count = '0;
        for (int i = 0; i < WIDTH; i++) begin
            load_count = load_count + CNT_W'(in_mask[i]);
        end
    end

    // armed_q holds in_ready low until the first edge after reset release.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            residual_q <= '0;
            cnt_q      <= '0;
            armed_q    <= 1'b0;
            empty_q    <= 1'b0;
        end else begin
            state_q    <= state_nx;
            residual_q <= residual_nx;
            cnt_q      <= cnt_nx;
            armed_q    <= 1'b1;
            empty_q    <= empty_nx;
        end
    end

    always_comb begin
        state_nx    = state_q;
        residual_nx = residual_q;
        cnt_nx      = cnt_q;
        empty_nx    = 1'b0;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        out_index   = '0;
        out_last    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = armed_q;
                if (in_valid && armed_q) begin
                    if (|in_mask) begin
                        residual_nx = in_mask;
                        cnt_nx      = load_count;
                        state_nx    = ST_SCAN;
                    end else begin
                        empty_nx = 1'b1;
                    end
                end
            end
            ST_SCAN: begin
                out_valid = enc_nonzero;
                out_index = enc_index;
                out_last  = (cnt_q == CNT_W'(1));
                if (out_ready && enc_nonzero) begin
                    // Clear the lowest set bit; residual is nonzero here so the decrement never wraps.
                    residual_nx = residual_q & (residual_q - WIDTH'(1));
                    cnt_nx      = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_nx = ST_IDLE;
                    end
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    assign remaining = cnt_q;
    assign empty     = empty_q;

endmodule

// File: tb/tb_set_bit_iterator_32.sv
// tb/tb_set_bit_iterator_32.sv - table-driven self-checking bench for set_bit_iterator_32
module tb_set_bit_iterator_32;

    logic        clock;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_mask;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_index;
    logic        out_last;
    logic [5:0]  remaining;
    logic        empty;

    int n_vec  = 0;
    int n_fail = 0;

    set_bit_iterator_32 dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mask   (in_mask),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_index (out_index),
        .out_last  (out_last),
        .remaining (remaining),
        .empty     (empty)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct {
        logic        iv;
        logic [31:0] m;
        logic        ordy;
        logic        e_rdy;
        logic        e_ov;
        logic [4:0]  e_idx;
        logic        e_last;
        logic [5:0]  e_rem;
        logic        e_emp;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic iv, logic [31:0] m, logic ordy, logic e_rdy, logic e_ov,
                                logic [4:0] e_idx, logic e_last, logic [5:0] e_rem, logic e_emp);
        vec_t v;
        v.iv = iv; v.m = m; v.ordy = ordy;
        v.e_rdy = e_rdy; v.e_ov = e_ov; v.e_idx = e_idx;
        v.e_last = e_last; v.e_rem = e_rem; v.e_emp = e_emp;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        in_valid  = v.iv;
        in_mask   = v.m;
        out_ready = v.ordy;
        #1;
        chk("in_ready",  idx, 32'(in_ready),  32'(v.e_rdy));
        chk("out_valid", idx, 32'(out_valid), 32'(v.e_ov));
        chk("out_index", idx, 32'(out_index), 32'(v.e_idx));
        chk("out_last",  idx, 32'(out_last),  32'(v.e_last));
        chk("remaining", idx, 32'(remaining), 32'(v.e_rem));
        chk("empty",     idx, 32'(empty),     32'(v.e_emp));
        @(negedge clock);
    endtask

    initial begin
        // sparse mask 0x8000_0001
        vecs.push_back(mk(1, 32'h8000_0001, 1, 1, 0, 0,  0, 0, 0));
        vecs.push_back(mk(0, 32'h0,         1, 0, 1, 0,  0, 2, 0));
        vecs.push_back(mk(0, 32'h0,         1, 0, 1, 31, 1, 1, 0));
        // zero mask
        vecs.push_back(mk(1, 32'h0,         1, 1, 0, 0,  0, 0, 0));
        vecs.push_back(mk(0, 32'h0,         1, 1, 0, 0,  0, 0, 1));
        vecs.push_back(mk(0, 32'h0,         1, 1, 0, 0,  0, 0, 0));
        // full mask, each index first stalled then taken
        vecs.push_back(mk(1, 32'hFFFF_FFFF, 1, 1, 0, 0,  0, 0, 0));
        for (int i = 0; i < 32; i++) begin
            vecs.push_back(mk(0, 32'h0, 0, 0, 1, 5'(i), (i == 31), 6'(32 - i), 0));
            vecs.push_back(mk(0, 32'h0, 1, 0, 1, 5'(i), (i == 31), 6'(32 - i), 0));
        end
        vecs.push_back(mk(0, 32'h0,         1, 1, 0, 0,  0, 0, 0));
        // mask offered during scan is ignored
        vecs.push_back(mk(1, 32'h0000_0300, 1, 1, 0, 0,  0, 0, 0));
        vecs.push_back(mk(1, 32'h0000_0001, 1, 0, 1, 8,  0, 2, 0));
        vecs.push_back(mk(1, 32'h0000_0001, 1, 0, 1, 9,  1, 1, 0));
        vecs.push_back(mk(1, 32'h0000_0001, 1, 1, 0, 0,  0, 0, 0));
        vecs.push_back(mk(0, 32'h0,         1, 0, 1, 0,  1, 1, 0));
        vecs.push_back(mk(0, 32'h0,         1, 1, 0, 0,  0, 0, 0));
        // back-to-back masks with in_valid held
        vecs.push_back(mk(1, 32'h0000_0001, 1, 1, 0, 0,  0, 0, 0));
        vecs.push_back(mk(1, 32'h4000_0000, 1, 0, 1, 0,  1, 1, 0));
        vecs.push_back(mk(1, 32'h4000_0000, 1, 1, 0, 0,  0, 0, 0));
        vecs.push_back(mk(0, 32'h0,         1, 0, 1, 30, 1, 1, 0));
        vecs.push_back(mk(0, 32'h0,         1, 1, 0, 0,  0, 0, 0));

        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_mask   = '0;
        out_ready = 1'b0;
        #3;
        chk("rst_in_ready",  0, 32'(in_ready),  32'h0);
        chk("rst_out_valid", 0, 32'(out_valid), 32'h0);
        chk("rst_out_index", 0, 32'(out_index), 32'h0);
        chk("rst_out_last",  0, 32'(out_last),  32'h0);
        chk("rst_remaining", 0, 32'(remaining), 32'h0);
        chk("rst_empty",     0, 32'(empty),     32'h0);
        #4 reset_n = 1'b1;
        @(negedge clock);
        chk("pre_edge_in_ready", 0, 32'(in_ready), 32'h0);
        @(negedge clock);

        foreach (vecs[i]) apply(vecs[i], i);

        // reset pulsed between edges mid-scan
        in_valid  = 1'b1;
        in_mask   = 32'h0000_00F0;
        out_ready = 1'b1;
        @(negedge clock);
        in_valid = 1'b0;
        #1;
        chk("ar_index", 0, 32'(out_index), 32'd4);
        chk("ar_rem",   0, 32'(remaining), 32'd4);
        @(posedge clock);
        #1;
        chk("ar_index", 1, 32'(out_index), 32'd5);
        #1 reset_n = 1'b0;
        #1;
        chk("ar_out_valid", 0, 32'(out_valid), 32'h0);
        chk("ar_out_index", 0, 32'(out_index), 32'h0);
        chk("ar_remaining", 0, 32'(remaining), 32'h0);
        chk("ar_in_ready",  0, 32'(in_ready),  32'h0);
        #1 reset_n = 1'b1;
        @(negedge clock);
        chk("ar_in_ready", 1, 32'(in_ready), 32'h0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            #1;
            chk("ar_post_in_ready",  c, 32'(in_ready),  32'h1);
            chk("ar_post_out_valid", c, 32'(out_valid), 32'h0);
            chk("ar_post_remaining", c, 32'(remaining), 32'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
